// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb game: FSM encodings, bus addresses,
// module version codes and small arithmetic helpers.
package bomb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ARMED    = 3'd2,
        EXPLODED = 3'd3,
        DEFUSED  = 3'd4
    } game_state_t;

    // Bus address meaning "nobody is selected"
    localparam logic [3:0] NO_MODULE = 4'hF;

    // Slot addresses of the puzzle modules on the shared setup bus
    localparam logic [3:0] SWITCHES_ADDRESS = 4'd0;
    localparam logic [3:0] WIRES_ADDRESS    = 4'd1;
    localparam logic [3:0] BUTTON_ADDRESS   = 4'd2;
    localparam logic [3:0] KEYPAD_ADDRESS   = 4'd3;

    // Puzzle variants a module may derive from its setup RNG value
    typedef enum logic [1:0] {
        VERSION_A = 2'd0,
        VERSION_B = 2'd1,
        VERSION_C = 2'd2,
        VERSION_D = 2'd3
    } version_t;

    // Number of set bits; slots never exceed 15 because address F is reserved
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bomb_game_controller_second_tick.sv
// Countdown prescaler: counts 0..CLKS_PER_SEC-1 while enabled and pulses
// tick_o for the single cycle in which the count wraps.
module second_tick #(
    parameter int CLKS_PER_SEC = 27_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and wrap pulse; clear has priority over counting
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Prescaler register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bomb_game_controller.sv
// Bomb game sequencer: hands each present puzzle slot its setup RNG value,
// then runs the countdown and folds strikes/defuses into one outcome.
module bomb_game_controller
    import bomb_pkg::*;
#(
    parameter int                   N_MODULES    = 4,
    parameter logic [N_MODULES-1:0] PRESENT_MASK = {N_MODULES{1'b1}},
    parameter int                   CLKS_PER_SEC = 27_000_000,
    parameter int                   TIME_LIMIT   = 300,
    parameter int                   MAX_STRIKES  = 3,
    parameter int                   SETUP_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           rng_value,
    input  logic [N_MODULES-1:0] mod_strike,
    input  logic [N_MODULES-1:0] mod_defused,
    output logic [3:0]           enable,
    output logic [3:0]           rng_out,
    output logic                 rng_advance,
    output logic [2:0]           game_state,
    output logic [8:0]           seconds_left,
    output logic [1:0]           strike_count,
    output logic                 exploded,
    output logic                 defused
);

    localparam int SC_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETUP_CYCLES - 1);

    game_state_t          state_q, state_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [SC_W-1:0]      scnt_q, scnt_d;
    logic [3:0]           enable_q, enable_d;
    logic [3:0]           rng_out_q, rng_out_d;
    logic                 rng_adv_q, rng_adv_d;
    logic [8:0]           seconds_q, seconds_d;
    logic [1:0]           strike_q, strike_d;
    logic                 exploded_q, exploded_d;
    logic                 defused_q, defused_d;
    logic [N_MODULES-1:0] strike_prev_q;

    logic                 first_found, next_found;
    logic [3:0]           first_idx, next_idx;
    logic [N_MODULES-1:0] strike_edges;
    logic [4:0]           strike_sum;
    logic [1:0]           strike_sat;
    logic                 all_defused;
    logic                 tick;

    second_tick #(
        .CLKS_PER_SEC(CLKS_PER_SEC)
    ) u_second_tick (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (state_q != ARMED),
        .enable_i (state_q == ARMED),
        .tick_o   (tick)
    );

    // Lowest present slot overall and lowest present slot above the pointer
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = N_MODULES - 1; i >= 0; i--) begin
            if (PRESENT_MASK[i]) begin
                first_found = 1'b1;
                first_idx   = 4'(i);
                if (4'(i) > ptr_q) begin
                    next_found = 1'b1;
                    next_idx   = 4'(i);
                end
            end
        end
    end

    // Rising strike edges of populated slots, added with saturation at 3
    assign strike_edges = mod_strike & ~strike_prev_q & PRESENT_MASK;
    assign strike_sum   = {3'b000, strike_q} + popcount16(16'(strike_edges));
    assign strike_sat   = (strike_sum > 5'd3) ? 2'd3 : strike_sum[1:0];
    assign all_defused  = ((mod_defused & PRESENT_MASK) == PRESENT_MASK);

    // Next state and next registered outputs. The strike explode test uses
    // the updated count so a final strike beats a same-cycle defuse.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        scnt_d     = scnt_q;
        enable_d   = enable_q;
        rng_out_d  = rng_out_q;
        rng_adv_d  = 1'b0;
        seconds_d  = seconds_q;
        strike_d   = strike_q;
        exploded_d = exploded_q;
        defused_d  = defused_q;
        case (state_q)
            IDLE: begin
                enable_d = NO_MODULE;
                if (start) begin
                    if (first_found) begin
                        state_d   = SETUP;
                        ptr_d     = first_idx;
                        scnt_d    = '0;
                        enable_d  = first_idx;
                        rng_out_d = rng_value;
                        rng_adv_d = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            SETUP: begin
                if (scnt_q == SC_LAST) begin
                    if (next_found) begin
                        ptr_d     = next_idx;
                        scnt_d    = '0;
                        enable_d  = next_idx;
                        rng_out_d = rng_value;
                        rng_adv_d = 1'b1;
                    end else begin
                        enable_d = NO_MODULE;
                        state_d  = ARMED;
                    end
                end else begin
                    scnt_d = scnt_q + SC_W'(1);
                end
            end
            ARMED: begin
                strike_d = strike_sat;
                if (tick && (seconds_q != 9'd0)) begin
                    seconds_d = seconds_q - 9'd1;
                end
                if ((seconds_q == 9'd0) || (int'(strike_sat) >= MAX_STRIKES)) begin
                    state_d    = EXPLODED;
                    exploded_d = 1'b1;
                end else if (all_defused) begin
                    state_d   = DEFUSED;
                    defused_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and output registers; the strike history always follows the input
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            scnt_q        <= '0;
            enable_q      <= NO_MODULE;
            rng_out_q     <= '0;
            rng_adv_q     <= 1'b0;
            seconds_q     <= 9'(TIME_LIMIT);
            strike_q      <= '0;
            exploded_q    <= 1'b0;
            defused_q     <= 1'b0;
            strike_prev_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            scnt_q        <= scnt_d;
            enable_q      <= enable_d;
            rng_out_q     <= rng_out_d;
            rng_adv_q     <= rng_adv_d;
            seconds_q     <= seconds_d;
            strike_q      <= strike_d;
            exploded_q    <= exploded_d;
            defused_q     <= defused_d;
            strike_prev_q <= mod_strike;
        end
    end

    assign enable       = enable_q;
    assign rng_out      = rng_out_q;
    assign rng_advance  = rng_adv_q;
    assign game_state   = state_q;
    assign seconds_left = seconds_q;
    assign strike_count = strike_q;
    assign exploded     = exploded_q;
    assign defused      = defused_q;

endmodule
